// File: rtl/counter_ld.sv
// Up/down counter with parallel load, programmable terminal value,
// wrap/saturate mode, terminal-count strobe and sticky overflow.
module counter_ld #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_down,
    input  logic         load,
    input  logic [n-1:0] d,
    input  logic [n-1:0] limit,
    input  logic         sat,
    output logic [n-1:0] q,
    output logic         tc,
    output logic         ovf
);

    logic [n-1:0] q_next;
    logic         ovf_next;
    logic [n:0]   q_inc;
    logic [n:0]   q_dec;
    logic [n:0]   lim_w;

    // Widened by one bit so limit = all ones needs no special case.
    assign q_inc = {1'b0, q} + 1'b1;
    assign q_dec = {1'b0, q} - 1'b1;
    assign lim_w = {1'b0, limit};

    always_comb begin
        q_next   = q;
        ovf_next = ovf;
        if (load) begin
            q_next   = (d > limit) ? limit : d;
            ovf_next = 1'b0;
        end else if (en) begin
            if (q > limit) begin
                // Stale count after limit was lowered; flag untouched.
                q_next = (up_down && !sat) ? '0 : limit;
            end else if (up_down) begin
                if (q_inc > lim_w) begin
                    q_next   = sat ? limit : '0;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q_inc[n-1:0];
                end
            end else begin
                if (q_dec[n]) begin
                    q_next   = sat ? '0 : limit;
                    ovf_next = 1'b1;
                end else begin
                    q_next = q_dec[n-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            ovf <= 1'b0;
        end else begin
            q   <= q_next;
            ovf <= ovf_next;
        end
    end

    assign tc = en & ((up_down & (q == limit)) | (~up_down & (q == '0)));

endmodule

// File: tb/tb_counter_ld.sv
// Randomised and directed checks of counter_ld against an
// integer reference model of the counting rules.
module tb_counter_ld;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] d;
    logic [7:0] limit;
    logic       sat;
    logic [7:0] q;
    logic       tc;
    logic       ovf;

    int n_cmp;
    int n_bad;
    int mq;
    int mo;
    bit mvalid;

    counter_ld #(.n(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up_down (up_down),
        .load    (load),
        .d       (d),
        .limit   (limit),
        .sat     (sat),
        .q       (q),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // One clock: check tc before the edge, advance the model, check after.
    task automatic cyc();
        int lim;
        int exp_tc;
        lim = int'(limit);
        #1;
        if (mvalid && !rst) begin
            exp_tc = (en && ((up_down && mq == lim) ||
                             (!up_down && mq == 0))) ? 1 : 0;
            chk("tc", int'(tc), exp_tc);
        end
        if (rst) begin
            mq = 0;
            mo = 0;
            mvalid = 1'b1;
        end else if (load) begin
            mq = (int'(d) < lim) ? int'(d) : lim;
            mo = 0;
        end else if (en) begin
            if (mq > lim) begin
                mq = (up_down && !sat) ? 0 : lim;
            end else if (up_down) begin
                if (mq == lim) begin
                    mq = sat ? lim : 0;
                    mo = 1;
                end else begin
                    mq = mq + 1;
                end
            end else begin
                if (mq == 0) begin
                    mq = sat ? 0 : lim;
                    mo = 1;
                end else begin
                    mq = mq - 1;
                end
            end
        end
        @(negedge clk);
        if (mvalid) begin
            chk("q", int'(q), mq);
            chk("ovf", int'(ovf), mo);
        end
    endtask

    task automatic idle();
        rst = 0; load = 0; en = 0;
    endtask

    task automatic do_load(input int dv, input int lv);
        idle();
        load = 1; d = 8'(dv); limit = 8'(lv);
        cyc();
        load = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; mq = 0; mo = 0; mvalid = 1'b0;
        rst = 1; en = 0; up_down = 1; load = 0;
        d = 0; limit = 8'd255; sat = 0;
        repeat (2) cyc();
        chk("rst_q", int'(q), 0);
        chk("rst_ovf", int'(ovf), 0);

        // Full-range count up with wrap
        idle(); en = 1; up_down = 1; limit = 8'd255; sat = 0;
        repeat (260) cyc();
        chk("up_wrap_q", int'(q), 4);
        chk("up_wrap_ovf", int'(ovf), 1);

        // Programmable wrap down
        do_load(3, 5);
        en = 1; up_down = 0; sat = 0;
        repeat (6) cyc();
        chk("dn_wrap_q", int'(q), 3);
        chk("dn_wrap_ovf", int'(ovf), 1);

        // Saturate both ways
        sat = 1;
        do_load(7, 9);
        en = 1; up_down = 1;
        repeat (5) cyc();
        chk("sat_up_q", int'(q), 9);
        chk("sat_up_ovf", int'(ovf), 1);
        up_down = 0;
        repeat (12) cyc();
        chk("sat_dn_q", int'(q), 0);

        // Load beats enable, clamps to limit
        idle(); en = 1; load = 1; d = 8'd200; limit = 8'd100;
        cyc();
        chk("clamp_q", int'(q), 100);
        chk("clamp_ovf", int'(ovf), 0);
        do_load(50, 100);
        chk("load_q", int'(q), 50);

        // Limit shrink below current count
        sat = 0;
        do_load(40, 255);
        limit = 8'd20; en = 1; up_down = 1;
        cyc();
        chk("shrink_up_wrap", int'(q), 0);
        sat = 1;
        do_load(40, 255);
        limit = 8'd20; en = 1; up_down = 1;
        cyc();
        chk("shrink_up_sat", int'(q), 20);
        do_load(40, 255);
        limit = 8'd20; en = 1; up_down = 0;
        cyc();
        chk("shrink_dn", int'(q), 20);

        // limit = 0 pins the count
        sat = 0;
        do_load(0, 0);
        en = 1; up_down = 1;
        repeat (3) cyc();
        chk("lim0_q", int'(q), 0);
        chk("lim0_ovf", int'(ovf), 1);

        // Reset wins over load, then hold
        idle(); limit = 8'd50; en = 1;
        repeat (4) cyc();
        rst = 1; load = 1; d = 8'd9;
        cyc();
        chk("rst_load_q", int'(q), 0);
        chk("rst_load_ovf", int'(ovf), 0);
        idle(); up_down = 1;
        repeat (10) cyc();
        chk("hold_tc", int'(tc), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(63) == 0);
            load = ($urandom_range(7) == 0);
            en = ($urandom_range(3) != 0);
            up_down = $urandom_range(1);
            sat = ($urandom_range(15) == 0) ? ~sat : sat;
            d = 8'($urandom);
            if ($urandom_range(15) == 0) begin
                limit = 8'($urandom);
                if (limit == 0 && mq != 0) limit = 8'd1;
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_ld.md
# counter_ld

Parametrised up/down counter with parallel load, a run-time programmable terminal value, and selectable wrap or saturate mode. It also provides a terminal-count strobe and a sticky overflow flag. It is the next generation of the catalog `counter` element, and serves as a timer, address generator, or loop counter inside datapath and control blocks. All state updates happen on the rising edge of `clk`.

## Interface
- `n`, default 8: counter width in bits; legal n >= 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset; highest priority.
- `en`  in  1: count enable; 1 = advance one step this cycle.
- `up_down`  in  1: direction; 1 = up (+1), 0 = down (-1).
- `load`  in  1: parallel load strobe; acts regardless of `en`.
- `d`  in  n: load value.
- `limit`  in  n: terminal value; the count range is 0..limit inclusive; sampled every cycle.
- `sat`  in  1: mode; 0 = wrap, 1 = saturate.
- `q`  out  n: registered count.
- `tc`  out  1: terminal count, combinational from registered state and inputs.
- `ovf`  out  1: registered, sticky overflow/underflow flag.

## Operation
- Next-state priority at each edge: `rst` > `load` > `en` > hold.
- `rst` = 1: `q` <= 0 and `ovf` <= 0.
- `load` = 1:
  - `q` <= min(`d`, `limit`); a value above `limit` is clamped to `limit`.
  - `ovf` <= 0.
- `en` = 1, `up_down` = 1 (up):
  - `q` < `limit`: `q` <= `q` + 1.
  - `q` == `limit`, wrap mode: `q` <= 0.
  - `q` == `limit`, saturate mode: `q` holds at `limit`.
  - In both terminal cases `ovf` <= 1.
- `en` = 1, `up_down` = 0 (down):
  - `q` > 0: `q` <= `q` - 1.
  - `q` == 0, wrap mode: `q` <= `limit`.
  - `q` == 0, saturate mode: `q` holds at 0.
  - In both terminal cases `ovf` <= 1.
- Out-of-range state: if `limit` is lowered while `q` > `limit`, the next enabled step does the following, and `ovf` is unchanged:
  - up, wrap: `q` <= 0.
  - up, saturate: `q` <= `limit`.
  - down, either mode: `q` <= `limit`.
- `limit` = 0: `q` is forced to 0 on every enabled step. `tc` stays 1 while `en` = 1. `ovf` is set on the first enabled step.
- `en` = 0 and `load` = 0: `q` and `ovf` hold.
- `tc` = `en` & ((`up_down` & (`q` == `limit`)) | (~`up_down` & (`q` == 0))). It marks the cycle in which the next edge wraps or saturates.
- Arithmetic is done n+1 bits wide internally, so the full range 0..2^n-1 is usable when `limit` = all ones. There is no hidden carry state.
- `ovf` stays set until `rst` or `load`. Counting back into range does not clear it.

## Timing
- Latency: one cycle. Inputs sampled at edge k appear on `q`/`ovf` after edge k.
- `tc` has zero latency relative to `q`. It is valid in the same cycle as the terminal `q` value and is qualified by the current `en` and `up_down`.
- Reset values: `q` = 0, `ovf` = 0.
- After reset, `tc` = `en` & ~`up_down`, because `q` == 0.
- Reset mid-count: on the edge where `rst` = 1, all in-flight `load`/`en` effects are discarded.
- Simultaneous `load` and `en`: the load wins and no step is applied that cycle.
- A direction change takes effect on the very next edge. There is no turnaround cycle.

## Test plan
- Reset and count up: `rst` for 2 cycles, then `en`=1, `up_down`=1, `limit`=255, `sat`=0 for 260 cycles.
  - `q` reads 0,1,…,255,0,1,2,3.
  - `tc`=1 only while `q`=255.
  - `ovf` rises on the edge after `q`=255.
- Programmable wrap down: load `d`=3, `limit`=5, `sat`=0, then `up_down`=0 for 6 cycles.
  - `q` reads 3,2,1,0,5,4,3.
  - `tc`=1 at `q`=0.
  - `ovf`=1 after the wrap.
- Saturate: `limit`=9, `sat`=1, load `d`=7, count up 5 cycles.
  - `q` reads 7,8,9,9,9.
  - `ovf`=1.
  - Then count down 12 cycles: `q` reaches 0 and holds.
- Load priority and clamp:
  - `load`=1 with `en`=1 and `d`=200, `limit`=100: `q`=100 next cycle and `ovf`=0.
  - `load` with `en`=0, `d`=50: `q`=50.
- Limit shrink: with `q`=40, set `limit`=20 and step once.
  - up, wrap: `q`=0.
  - up, saturate: `q`=20.
  - down: `q`=20.
- Reset mid-operation and hold:
  - Assert `rst` together with `load`, `d`=9: `q`=0 and `ovf`=0.
  - `en`=0 for 10 cycles: `q` and `ovf` unchanged, and `tc`=0.
